// File: rtl/hazard_scheduler.sv
// hazard_scheduler: N-stage stall/flush/redirect controller with a pending-redirect buffer, a stall watchdog and saturating perf counters
module hazard_scheduler #(
  parameter int NUM_STAGES = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DELAY_SLOT = 1,
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_STAGES-1:0]            stall_req,
  input  logic [NUM_STAGES-1:0]            flush_req,
  input  logic [NUM_STAGES-1:0]            redirect_valid,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] redirect_pc,
  output logic [NUM_STAGES-1:0]            redirect_ack,
  output logic                             pc_stall,
  output logic [NUM_STAGES-1:0]            reg_stall,
  output logic [NUM_STAGES-1:0]            reg_flush,
  output logic                             load_pc_we,
  output logic [ADDR_WIDTH-1:0]            load_pc_new_pc,
  input  logic                             pc_ready,
  output logic                             wdog_timeout,
  input  logic                             perf_clear,
  output logic [CNT_WIDTH-1:0]             cnt_stall,
  output logic [CNT_WIDTH-1:0]             cnt_bubble,
  output logic [CNT_WIDTH-1:0]             cnt_redirect
);
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam int PW = $clog2(NUM_STAGES + 1);
  localparam int RW = $clog2(WDOG_LIMIT + 1);
  localparam int SW = CNT_WIDTH + PW;
  logic [NUM_STAGES:0]   w_ss;
  logic [NUM_STAGES-1:0] w_elig, w_kill, w_stall, w_flush;
  logic                  w_run, w_cand_v, w_win;
  logic [IW-1:0]         w_cand_idx;
  logic [ADDR_WIDTH-1:0] w_cand_pc;
  logic [PW-1:0]         w_pop;
  logic [RW-1:0]         w_run_nxt;
  logic                  r_pend_v, r_wdog;
  logic [IW-1:0]         r_pend_idx;
  logic [ADDR_WIDTH-1:0] r_pend_pc;
  logic [RW-1:0]         r_run;
  logic [CNT_WIDTH-1:0]  r_cnt_stall, r_cnt_bubble, r_cnt_redir;
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a, input logic [PW-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return s > SW'({CNT_WIDTH{1'b1}}) ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction
  assign w_run = ~rst;
  always_comb begin
    w_ss = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) w_ss[i] = stall_req[i] | w_ss[i+1];
  end
  assign w_elig  = redirect_valid & ~w_ss[NUM_STAGES-1:0];
  assign w_stall = w_ss[NUM_STAGES:1];
  // ascending scan so the oldest (highest-index) eligible stage ends up selected
  always_comb begin
    w_cand_v   = 1'b0;
    w_cand_idx = '0;
    w_cand_pc  = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (w_elig[i]) begin
        w_cand_v   = 1'b1;
        w_cand_idx = IW'(i);
        w_cand_pc  = redirect_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
  end
  assign w_win = w_run & w_cand_v & (~r_pend_v | (w_cand_idx >= r_pend_idx));
  always_comb begin
    w_kill = '0;
    for (int i = 0; i < NUM_STAGES; i++) w_kill[i] = w_win & (i <= int'(w_cand_idx) - 1 - DELAY_SLOT);
    w_kill[0] = w_kill[0] | r_pend_v;
  end
  assign w_flush        = ~w_stall & ((w_ss[NUM_STAGES-1:0] & ~w_stall) | flush_req | w_kill);
  assign reg_stall      = w_run ? w_stall : '0;
  assign reg_flush      = w_run ? w_flush : '0;
  assign redirect_ack   = w_win ? (NUM_STAGES'(1) << w_cand_idx) : '0;
  assign pc_stall       = w_run & ((stall_req[0] & ~(w_win | r_pend_v)) | w_ss[1]);
  assign load_pc_we     = w_win | r_pend_v;
  assign load_pc_new_pc = w_win ? w_cand_pc : r_pend_pc;
  assign wdog_timeout   = r_wdog;
  assign cnt_stall      = r_cnt_stall;
  assign cnt_bubble     = r_cnt_bubble;
  assign cnt_redirect   = r_cnt_redir;
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_STAGES; i++) w_pop = w_pop + PW'(reg_flush[i]);
  end
  assign w_run_nxt = ~pc_stall ? '0 : (r_run == RW'(WDOG_LIMIT)) ? r_run : r_run + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_v     <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_pc    <= '0;
      r_run        <= '0;
      r_wdog       <= 1'b0;
      r_cnt_stall  <= '0;
      r_cnt_bubble <= '0;
      r_cnt_redir  <= '0;
    end else begin
      if (load_pc_we) begin
        r_pend_v   <= ~pc_ready;
        r_pend_idx <= w_win ? w_cand_idx : r_pend_idx;
        r_pend_pc  <= load_pc_new_pc;
      end
      if (perf_clear) begin
        r_run        <= '0;
        r_wdog       <= 1'b0;
        r_cnt_stall  <= '0;
        r_cnt_bubble <= '0;
        r_cnt_redir  <= '0;
      end else begin
        r_run        <= w_run_nxt;
        r_wdog       <= r_wdog | (w_run_nxt == RW'(WDOG_LIMIT));
        r_cnt_stall  <= sat_add(r_cnt_stall, PW'(pc_stall));
        r_cnt_bubble <= sat_add(r_cnt_bubble, w_pop);
        r_cnt_redir  <= sat_add(r_cnt_redir, PW'(w_win));
      end
    end
  end
endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed checks of stall chain, redirect arbitration, pending buffer, watchdog and counters
module tb_hazard_scheduler;
  localparam int N = 5;
  localparam int AW = 32;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  stall_req = '0, flush_req = '0, redirect_valid = '0;
  logic [N*AW-1:0] redirect_pc = '0;
  logic [N-1:0]  redirect_ack, reg_stall, reg_flush;
  logic          pc_stall, load_pc_we, pc_ready = 1'b0, wdog_timeout, perf_clear = 1'b0;
  logic [AW-1:0] load_pc_new_pc;
  logic [CW-1:0] cnt_stall, cnt_bubble, cnt_redirect;
  int n_cmp = 0;
  int n_err = 0;
  hazard_scheduler #(.NUM_STAGES(N), .ADDR_WIDTH(AW), .DELAY_SLOT(1), .WDOG_LIMIT(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack),
    .pc_stall(pc_stall), .reg_stall(reg_stall), .reg_flush(reg_flush),
    .load_pc_we(load_pc_we), .load_pc_new_pc(load_pc_new_pc), .pc_ready(pc_ready),
    .wdog_timeout(wdog_timeout), .perf_clear(perf_clear),
    .cnt_stall(cnt_stall), .cnt_bubble(cnt_bubble), .cnt_redirect(cnt_redirect));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_pc_stall", pc_stall, 0);
    chk("rst_load", load_pc_we, 0);
    chk("rst_flush", reg_flush, 0);
    chk("rst_cnt", cnt_stall, 0);
    #1 rst = 1'b0;
    tick();
    stall_req = 5'b00001;
    #1;
    chk("t1_pc_stall", pc_stall, 1);
    chk("t1_flush", reg_flush, 5'b00001);
    chk("t1_stall", reg_stall, 0);
    chk("t1_cnt0", cnt_stall, 0);
    tick();
    chk("t1_cnt1", cnt_stall, 1);
    tick();
    chk("t1_cnt2", cnt_stall, 2);
    chk("t1_bubble2", cnt_bubble, 2);
    stall_req = 5'b01000;
    #1;
    chk("t2_stall", reg_stall, 5'b00111);
    chk("t2_flush", reg_flush, 5'b01000);
    chk("t2_pc_stall", pc_stall, 1);
    tick();
    chk("t2_cnt3", cnt_stall, 3);
    stall_req = '0;
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    chk("clr_cnt", cnt_stall, 0);
    chk("clr_bubble", cnt_bubble, 0);
    chk("t2_wdog", wdog_timeout, 0);
    redirect_pc[2*AW +: AW] = 32'h100;
    redirect_pc[1*AW +: AW] = 32'h200;
    redirect_valid = 5'b00110;
    stall_req = 5'b00001;
    pc_ready = 1'b1;
    #1;
    chk("t3_ack", redirect_ack, 5'b00100);
    chk("t3_we", load_pc_we, 1);
    chk("t3_pc", load_pc_new_pc, 32'h100);
    chk("t3_pc_stall", pc_stall, 0);
    chk("t3_flush", reg_flush[1:0], 2'b01);
    tick();
    redirect_valid = '0;
    stall_req = '0;
    #1;
    chk("t3_cnt_redir", cnt_redirect, 1);
    chk("t3_no_pend", load_pc_we, 0);
    pc_ready = 1'b0;
    redirect_valid = 5'b00100;
    #1;
    chk("t4_ack2", redirect_ack, 5'b00100);
    chk("t4_pc", load_pc_new_pc, 32'h100);
    tick();
    redirect_valid = '0;
    #1;
    chk("t4_hold_we", load_pc_we, 1);
    chk("t4_hold_pc", load_pc_new_pc, 32'h100);
    chk("t4_kill0", reg_flush, 5'b00001);
    chk("t4_hold_ack", redirect_ack, 0);
    redirect_valid = 5'b00010;
    #1;
    chk("t4_s1_noack", redirect_ack, 0);
    chk("t4_s1_pc", load_pc_new_pc, 32'h100);
    tick();
    redirect_pc[3*AW +: AW] = 32'h300;
    redirect_valid = 5'b01010;
    #1;
    chk("t4_s3_ack", redirect_ack, 5'b01000);
    chk("t4_s3_pc", load_pc_new_pc, 32'h300);
    chk("t4_s3_flush", reg_flush, 5'b00011);
    tick();
    redirect_valid = 5'b00010;
    #1;
    chk("t4_pend3_noack", redirect_ack, 0);
    chk("t4_pend3_pc", load_pc_new_pc, 32'h300);
    pc_ready = 1'b1;
    #1;
    chk("t4_ready_we", load_pc_we, 1);
    chk("t4_ready_pc", load_pc_new_pc, 32'h300);
    tick();
    redirect_valid = '0;
    #1;
    chk("t4_cleared", load_pc_we, 0);
    chk("t4_cnt_redir", cnt_redirect, 3);
    stall_req = 5'b00001;
    tick();
    tick();
    tick();
    chk("t5_wdog3", wdog_timeout, 0);
    tick();
    chk("t5_wdog4", wdog_timeout, 1);
    stall_req = '0;
    tick();
    chk("t5_sticky", wdog_timeout, 1);
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    chk("t5_clr", wdog_timeout, 0);
    stall_req = 5'b00001;
    for (int k = 0; k < 20; k++) tick();
    chk("t6_sat_stall", cnt_stall, 4'hF);
    chk("t6_sat_bubble", cnt_bubble, 4'hF);
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    chk("t6_clr_discard", cnt_stall, 0);
    stall_req = '0;
    pc_ready = 1'b0;
    redirect_valid = 5'b00100;
    tick();
    redirect_valid = '0;
    #1;
    chk("t6_pending", load_pc_we, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_we", load_pc_we, 0);
    chk("t6_rst_flush", reg_flush, 0);
    #1 rst = 1'b0;
    pc_ready = 1'b1;
    tick();
    chk("t6_after_we", load_pc_we, 0);
    chk("t6_after_ack", redirect_ack, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
